// File: rtl/alu_share_arbiter_if.sv
// Bundle of requester-side and shared-unit-side signals for alu_share_arbiter.
// The arbiter takes the slave view; requesters and the add/sub unit take the master view.
interface alu_share_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] req_n0;
    logic [NREQ*W-1:0] req_n1;
    logic [NREQ-1:0]   req_opt;
    logic [NREQ-1:0]   gnt;
    logic [W-1:0]      in_n0;
    logic [W-1:0]      in_n1;
    logic              opt;
    logic [W-1:0]      out_n;
    logic              out_valid;
    logic [IDW-1:0]    out_id;
    logic [W-1:0]      out_data;
    logic              busy;

    modport slave (
        input  req, req_n0, req_n1, req_opt, out_n,
        output gnt, in_n0, in_n1, opt, out_valid, out_id, out_data, busy
    );

    modport master (
        output req, req_n0, req_n1, req_opt, out_n,
        input  gnt, in_n0, in_n1, opt, out_valid, out_id, out_data, busy
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one fixed-latency add/sub unit between NREQ requesters;
// latches the winner's operands, waits ALU_LAT cycles, returns the result tagged with its ID.
module alu_share_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 4,
    parameter int ALU_LAT = 1,
    parameter int IDW     = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    alu_share_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q;
    logic [IDW-1:0] ptr_q;
    logic [2:0]     cnt_q;
    logic [W-1:0]   in_n0_q;
    logic [W-1:0]   in_n1_q;
    logic           opt_q;
    logic           out_valid_q;
    logic [IDW-1:0] out_id_q;
    logic [W-1:0]   out_data_q;
    logic           busy_q;

    logic [IDW-1:0] cand_idx [NREQ];
    logic [NREQ-1:0] cand_hit;
    logic [IDW-1:0] sel_d;
    logic           sel_vld_d;
    logic [NREQ-1:0] gnt_d;

    // Candidate gi is the requester gi+1 places after the last winner.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
        assign cand_idx[gi] = IDW'((int'(ptr_q) + gi + 1) % NREQ);
        assign cand_hit[gi] = bus.req[cand_idx[gi]];
    end

    always_comb begin
        sel_vld_d = 1'b0;
        sel_d     = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (cand_hit[i]) begin
                sel_vld_d = 1'b1;
                sel_d     = cand_idx[i];
            end
        end
    end

    // A grant in a reset cycle would be discarded by the reset edge, so it is suppressed.
    always_comb begin
        gnt_d = '0;
        if (state_q == S_IDLE && sel_vld_d && !RST) begin
            gnt_d[sel_d] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            ptr_q       <= IDW'(NREQ - 1);
            cnt_q       <= '0;
            in_n0_q     <= '0;
            in_n1_q     <= '0;
            opt_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    out_valid_q <= 1'b0;
                    if (sel_vld_d) begin
                        in_n0_q <= bus.req_n0[int'(sel_d)*W +: W];
                        in_n1_q <= bus.req_n1[int'(sel_d)*W +: W];
                        opt_q   <= bus.req_opt[sel_d];
                        ptr_q   <= sel_d;
                        cnt_q   <= 3'(ALU_LAT);
                        busy_q  <= 1'b1;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q != 3'd0) begin
                        cnt_q <= cnt_q - 3'd1;
                    end else begin
                        out_data_q  <= bus.out_n;
                        out_id_q    <= ptr_q;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt       = gnt_d;
    assign bus.in_n0     = in_n0_q;
    assign bus.in_n1     = in_n1_q;
    assign bus.opt       = opt_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_id    = out_id_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed steps then random traffic, every cycle compared
// against a timing/priority model derived from grant times and round-robin order.
module tb_alu_share_arbiter #(
    parameter int ALU_LAT = 1
);
    localparam int NREQ = 4;
    localparam int W    = 4;
    localparam int IDW  = 2;
    localparam int PER  = ALU_LAT + 3;

    logic clk = 1'b0;
    logic tb_rst;
    always #5 clk = ~clk;

    alu_share_arbiter_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) bus ();

    alu_share_arbiter #(.NREQ(NREQ), .W(W), .ALU_LAT(ALU_LAT), .IDW(IDW)) dut (
        .CLK (clk),
        .RST (tb_rst),
        .bus (bus)
    );

    function automatic logic [W-1:0] alu(input logic [W-1:0] a, input logic [W-1:0] b, input logic o);
        return o ? W'(a - b) : W'(a + b);
    endfunction

    // Shared add/sub unit with ALU_LAT register stages.
    logic [W-1:0] unit_comb;
    assign unit_comb = alu(bus.in_n0, bus.in_n1, bus.opt);
    if (ALU_LAT == 0) begin : g_unit0
        assign bus.out_n = unit_comb;
    end else begin : g_unitn
        logic [W-1:0] pipe [ALU_LAT];
        always @(posedge clk) begin
            pipe[0] <= unit_comb;
            for (int i = 1; i < ALU_LAT; i++) pipe[i] <= pipe[i-1];
        end
        assign bus.out_n = pipe[ALU_LAT-1];
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [NREQ-1:0] want;
    logic [W-1:0] op_a [NREQ];
    logic [W-1:0] op_b [NREQ];
    logic         op_o [NREQ];
    logic         auto_drop;

    // Reference model state: expressed as event times rather than FSM states.
    int           m_ptr = NREQ - 1;
    int           m_free_at = 0;
    int           m_gcyc = -100;
    int           m_out_cycle = -1;
    logic [W-1:0] m_in0 = '0, m_in1 = '0;
    logic         m_opt = 1'b0;
    logic [W-1:0] m_pend_data = '0, m_last_data = '0;
    int           m_pend_id = 0, m_last_id = 0;

    int           dut_valid_cnt = 0;
    logic [W-1:0] dut_last_data = '0;
    logic [IDW-1:0] dut_last_id = '0;
    int           dut_glog [$];
    int           dut_gcyc [$];

    function automatic int pick(input int p, input logic [NREQ-1:0] r);
        for (int i = 1; i <= NREQ; i++) begin
            int j;
            j = (p + i) % NREQ;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic run_cycle();
        int k;
        logic [NREQ-1:0] eg;
        bus.req = want;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_n0[i*W +: W] = op_a[i];
            bus.req_n1[i*W +: W] = op_b[i];
            bus.req_opt[i]       = op_o[i];
        end
        #1;
        k = -1;
        if (!tb_rst && cyc >= m_free_at) k = pick(m_ptr, want);
        eg = '0;
        if (k >= 0) eg[k] = 1'b1;
        if (cyc == m_out_cycle) begin
            m_last_data = m_pend_data;
            m_last_id   = m_pend_id;
        end
        chk("gnt", 32'(bus.gnt), 32'(eg));
        chk("in_n0", 32'(bus.in_n0), 32'(m_in0));
        chk("in_n1", 32'(bus.in_n1), 32'(m_in1));
        chk("opt", 32'(bus.opt), 32'(m_opt));
        chk("out_valid", 32'(bus.out_valid), 32'(cyc == m_out_cycle));
        chk("out_id", 32'(bus.out_id), 32'(m_last_id));
        chk("out_data", 32'(bus.out_data), 32'(m_last_data));
        chk("busy", 32'(bus.busy), 32'(cyc > m_gcyc && cyc < m_free_at));
        if (bus.out_valid === 1'b1) begin
            dut_valid_cnt++;
            dut_last_data = bus.out_data;
            dut_last_id   = bus.out_id;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (bus.gnt[i] === 1'b1) begin
                dut_glog.push_back(i);
                dut_gcyc.push_back(cyc);
            end
        end
        if (tb_rst) begin
            m_ptr = NREQ - 1; m_free_at = cyc + 1; m_gcyc = -100; m_out_cycle = -1;
            m_in0 = '0; m_in1 = '0; m_opt = 1'b0; m_last_data = '0; m_last_id = 0;
        end else if (k >= 0) begin
            m_ptr = k; m_gcyc = cyc; m_free_at = cyc + PER; m_out_cycle = cyc + 2 + ALU_LAT;
            m_in0 = op_a[k]; m_in1 = op_b[k]; m_opt = op_o[k];
            m_pend_data = alu(op_a[k], op_b[k], op_o[k]);
            m_pend_id = k;
            if (auto_drop) want[k] = 1'b0;
        end
        $display("cyc=%0d rst=%0b req=%b gnt=%b in=%0h/%0h/%0b valid=%0b id=%0d data=%0h busy=%0b",
                 cyc, tb_rst, want, bus.gnt, bus.in_n0, bus.in_n1, bus.opt,
                 bus.out_valid, bus.out_id, bus.out_data, bus.busy);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        tb_rst = 1'b1; want = '0; auto_drop = 1'b1;
        for (int i = 0; i < NREQ; i++) begin op_a[i] = '0; op_b[i] = '0; op_o[i] = 1'b0; end
        bus.req = '0; bus.req_n0 = '0; bus.req_n1 = '0; bus.req_opt = '0;
        repeat (2) @(negedge clk);

        // Reset state
        run_cycle();
        tb_rst = 1'b0;

        // Requester 0: 3 + 5
        want = 4'b0001; op_a[0] = 4'd3; op_b[0] = 4'd5; op_o[0] = 1'b0;
        run_n(PER + 1);
        chk("add_data", 32'(dut_last_data), 32'd8);
        chk("add_id", 32'(dut_last_id), 32'd0);

        // Requester 2: 2 - 5 wraps, then 7 + 7
        want = 4'b0100; op_a[2] = 4'd2; op_b[2] = 4'd5; op_o[2] = 1'b1;
        run_n(PER + 1);
        chk("sub_data", 32'(dut_last_data), 32'hD);
        chk("sub_id", 32'(dut_last_id), 32'd2);
        want = 4'b0100; op_a[2] = 4'd7; op_b[2] = 4'd7; op_o[2] = 1'b0;
        run_n(PER + 1);
        chk("add77_data", 32'(dut_last_data), 32'hE);

        // All four held from reset: rotation 0,1,2,3,0 at fixed spacing
        tb_rst = 1'b1; run_cycle(); tb_rst = 1'b0;
        dut_glog.delete(); dut_gcyc.delete();
        for (int i = 0; i < NREQ; i++) begin op_a[i] = 4'(i + 1); op_b[i] = 4'(2 * i); op_o[i] = 1'(i % 2); end
        want = 4'b1111; auto_drop = 1'b0;
        run_n(4 * PER + 1);
        chk("rr_count", 32'(dut_glog.size()), 32'd5);
        if (dut_glog.size() == 5) begin
            chk("rr_g0", 32'(dut_glog[0]), 32'd0);
            chk("rr_g1", 32'(dut_glog[1]), 32'd1);
            chk("rr_g2", 32'(dut_glog[2]), 32'd2);
            chk("rr_g3", 32'(dut_glog[3]), 32'd3);
            chk("rr_g4", 32'(dut_glog[4]), 32'd0);
            chk("rr_gap", 32'(dut_gcyc[4] - dut_gcyc[3]), 32'(PER));
        end
        want = '0; auto_drop = 1'b1;
        run_n(PER);

        // Pointer at 1, then 0 and 2 together: 2 wins first
        want = 4'b0010;
        run_n(PER + 1);
        dut_glog.delete();
        want = 4'b0101;
        run_n(2 * PER + 2);
        chk("ptr_count", 32'(dut_glog.size()), 32'd2);
        if (dut_glog.size() == 2) begin
            chk("ptr_first", 32'(dut_glog[0]), 32'd2);
            chk("ptr_second", 32'(dut_glog[1]), 32'd0);
        end

        // Reset in WAIT aborts the operation silently
        want = 4'b0001; op_a[0] = 4'd9; op_b[0] = 4'd4; op_o[0] = 1'b1;
        run_cycle();
        v0 = dut_valid_cnt;
        tb_rst = 1'b1; run_cycle(); tb_rst = 1'b0;
        run_n(PER + 1);
        chk("abort_no_valid", 32'(dut_valid_cnt - v0), 32'd0);
        want = 4'b0001; op_a[0] = 4'd6; op_b[0] = 4'd1; op_o[0] = 1'b1;
        run_n(PER + 1);
        chk("post_abort_data", 32'(dut_last_data), 32'd5);

        // Random traffic, operands churning every cycle
        for (int n = 0; n < 500; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                op_a[i] = 4'($urandom_range(0, 15));
                op_b[i] = 4'($urandom_range(0, 15));
                op_o[i] = 1'($urandom_range(0, 1));
                if (!want[i] && $urandom_range(0, 3) == 0) want[i] = 1'b1;
                else if (want[i] && $urandom_range(0, 15) == 0) want[i] = 1'b0;
            end
            auto_drop = ($urandom_range(0, 3) != 0);
            tb_rst = ($urandom_range(0, 63) == 0);
            run_cycle();
        end
        tb_rst = 1'b0; want = '0;
        run_n(PER + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
